alu_control_display: RTL and testbench
======================================

# alu_control_display

Registered, parametrised successor to the combinational ALU control decoder. Decodes `alu_op` plus the R-type funct field into the 4-bit ALU control word, flags unsupported funct codes, and drives a DIGITS-wide active-low seven-segment bank with the operation mnemonic. The bank can show the mnemonic statically or scroll it as a marquee. Sits between the main control unit and the ALU; the segment outputs go to the board display pins.

## Interface
- `DIGITS`, 5: number of seven-segment digits, legal range 3..8.
- `SCROLL_DIV`, 25_000_000: clock cycles per scroll step, minimum 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `dec_valid` input 1: `alu_op`/`funct` are valid this cycle and are captured.
- `alu_op` input 2: 00 load/store, 01 branch-equal, 10 R-type, 11 logical-immediate.
- `funct` input 6: R-type function field; ignored unless `alu_op`=10.
- `scroll_en` input 1: 1 selects marquee display, 0 selects static display.
- `alu_control` output 4: registered ALU control word.
- `ctrl_valid` output 1: one-cycle pulse marking an `alu_control` update.
- `illegal` output 1: one-cycle pulse marking an unsupported funct.
- `seg` output DIGITS*7: segment bus. Digit 0 (leftmost) is at `[DIGITS*7-1 -: 7]`. Per digit, bits 6..0 = g,f,e,d,c,b,a. Active-low.

## Operation
- Decode on `dec_valid`:
  - `alu_op` 00 → 0010, mnemonic "LS ".
  - `alu_op` 01 → 0110, mnemonic "bEq".
  - `alu_op` 11 → 0000, mnemonic "And".
  - `alu_op` 10, by funct:
    - 100000 → 0010, "Add"
    - 100010 → 0110, "Sub"
    - 100100 → 0000, "And"
    - 100101 → 0001, "Or "
    - 101010 → 0111, "SLt"
    - 100111 → 1100, "nor" (configurable)
- Illegal funct:
  - `alu_control` holds its previous value.
  - `illegal` pulses.
  - Mnemonic becomes "Err".
  - `ctrl_valid` does not pulse.
- Glyphs (hex, active-low):
  - blank 7F, A 08, d 21, S 12, U 41, b 03, E 06, q 18
  - L 47, t 07, O 40, r 2F, n 2B
- Message ring:
  - Length L = DIGITS+3: the 3 mnemonic characters followed by DIGITS blanks.
  - Digit i shows ring[(offset+i) mod L].
- Static mode (`scroll_en`=0): offset forced to 0, so the mnemonic is left-justified and the remaining digits are blank.
- Scroll FSM, states IDLE and SCROLL:
  - IDLE: offset 0, prescaler 0. Moves to SCROLL when `scroll_en`=1.
  - SCROLL: prescaler counts 0..SCROLL_DIV-1. On terminal count, offset increments and wraps from L-1 to 0. Returns to IDLE when `scroll_en`=0.
- Any mnemonic load (legal or illegal) zeroes both offset and prescaler, in either state.

## Timing
- Latency: `dec_valid` sampled at edge N → `alu_control`, `ctrl_valid`/`illegal` and `seg` change at edge N, visible in cycle N+1. One cycle, registered outputs, no combinational input-to-output path.
- Back-to-back `dec_valid` is supported every cycle; each capture is independent.
- `ctrl_valid` and `illegal` are mutually exclusive single-cycle pulses.
- Scroll step: with `scroll_en` high and no new decode, offset advances exactly every SCROLL_DIV cycles. The first step occurs SCROLL_DIV cycles after entering SCROLL or after the last load.
- Decode load in the same cycle as a prescaler terminal count: the load wins, offset = 0.
- `scroll_en` deasserted mid-count: the next cycle shows offset 0, and the prescaler is cleared.
- Reset (`rst_n` low at an edge), including mid-scroll:
  - `alu_control`=0000, `ctrl_valid`=0, `illegal`=0
  - all digits 7F
  - FSM in IDLE, offset 0, prescaler 0, mnemonic register blank
- `dec_valid` during reset is ignored.

## Configuration
- `ALU_CTRL_NOR_EN` defined: funct 100111 decodes to 1100 with mnemonic "nor".
- Undefined: 100111 is illegal (`illegal` pulse, "Err", `alu_control` held). All other behaviour is identical.

## Test plan
- Reset, then `dec_valid` with `alu_op`=10, `funct`=100000, DIGITS=5 → the next cycle shows `alu_control`=0010, a single `ctrl_valid` pulse, and `seg` = 08,21,21,7F,7F.
- Load `funct`=100010, then `funct`=111111 on the next cycle → `alu_control` 0110 then held at 0110. `illegal` pulses once. `seg` = 06,2F,2F,7F,7F.
- `alu_op`=01 with SCROLL_DIV=4, `scroll_en`=1:
  - Digit 0 reads 03 → 06 → 18 → 7F at 4-cycle intervals.
  - Offset returns to 0 after 8 steps (L=8).
- Mid-scroll, a new decode lands on the prescaler terminal-count cycle → offset 0, with the full new mnemonic left-justified.
- Mid-scroll, `rst_n` low for one cycle → all outputs at reset values. Scrolling resumes only after a new load.
- Run `funct`=100111 once with `ALU_CTRL_NOR_EN` defined and once without:
  - Defined: 1100 and "nor" (2B,40,2F).
  - Undefined: an `illegal` pulse, "Err", and the prior `alu_control` held.

Source files
------------

// File: rtl/alu_control_display.sv
// Registered ALU control decoder with a DIGITS-wide active-low seven-segment mnemonic display (static or marquee).
// Define ALU_CTRL_NOR_EN to decode R-type funct 100111 as NOR; otherwise that code is reported as illegal.
module alu_control_display #(
  parameter int DIGITS     = 5,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  dec_valid_i,
  input  logic [1:0]            alu_op_i,
  input  logic [5:0]            funct_i,
  input  logic                  scroll_en_i,
  output logic [3:0]            alu_control_o,
  output logic                  ctrl_valid_o,
  output logic                  illegal_o,
  output logic [DIGITS*7-1:0]   seg_o
);

  localparam int L  = DIGITS + 3;
  localparam int OW = $clog2(L);
  localparam int PW = $clog2(SCROLL_DIV);

  localparam logic [6:0] G_BL = 7'h7F, G_A = 7'h08, G_D = 7'h21, G_S = 7'h12, G_U = 7'h41;
  localparam logic [6:0] G_B  = 7'h03, G_E = 7'h06, G_Q = 7'h18, G_L = 7'h47, G_T = 7'h07;
  localparam logic [6:0] G_O  = 7'h40, G_R = 7'h2F, G_N = 7'h2B;

  typedef enum logic {S_IDLE, S_SCROLL} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0][6:0] mnem_q, mnem_d;
  logic [3:0]      alu_control_q, alu_control_d;
  logic            ctrl_valid_q, ctrl_valid_d;
  logic            illegal_q, illegal_d;

  logic            dec_legal;
  logic [3:0]      dec_ctrl;
  logic [2:0][6:0] dec_mnem;

  // Character 0 of the mnemonic lives at index 0.
  function automatic logic [20:0] pack3(input logic [6:0] c0, input logic [6:0] c1,
                                        input logic [6:0] c2);
    return {c2, c1, c0};
  endfunction

  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 4'b0000;
    dec_mnem  = pack3(G_E, G_R, G_R);
    case (alu_op_i)
      2'b00: begin dec_ctrl = 4'b0010; dec_mnem = pack3(G_L, G_S, G_BL); end
      2'b01: begin dec_ctrl = 4'b0110; dec_mnem = pack3(G_B, G_E, G_Q); end
      2'b11: begin dec_ctrl = 4'b0000; dec_mnem = pack3(G_A, G_N, G_D); end
      default: begin
        case (funct_i)
          6'b100000: begin dec_ctrl = 4'b0010; dec_mnem = pack3(G_A, G_D, G_D); end
          6'b100010: begin dec_ctrl = 4'b0110; dec_mnem = pack3(G_S, G_U, G_B); end
          6'b100100: begin dec_ctrl = 4'b0000; dec_mnem = pack3(G_A, G_N, G_D); end
          6'b100101: begin dec_ctrl = 4'b0001; dec_mnem = pack3(G_O, G_R, G_BL); end
          6'b101010: begin dec_ctrl = 4'b0111; dec_mnem = pack3(G_S, G_L, G_T); end
`ifdef ALU_CTRL_NOR_EN
          6'b100111: begin dec_ctrl = 4'b1100; dec_mnem = pack3(G_N, G_O, G_R); end
`endif
          default:   dec_legal = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    presc_d       = presc_q;
    mnem_d        = mnem_q;
    alu_control_d = alu_control_q;
    ctrl_valid_d  = 1'b0;
    illegal_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        offset_d = '0;
        presc_d  = '0;
        if (scroll_en_i) state_d = S_SCROLL;
      end
      S_SCROLL: begin
        if (!scroll_en_i) begin
          state_d  = S_IDLE;
          offset_d = '0;
          presc_d  = '0;
        end else if (presc_q == PW'(SCROLL_DIV - 1)) begin
          presc_d  = '0;
          offset_d = (offset_q == OW'(L - 1)) ? '0 : offset_q + OW'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    // A load restarts the marquee from the left edge, even on a terminal-count cycle.
    if (dec_valid_i) begin
      offset_d = '0;
      presc_d  = '0;
      mnem_d   = dec_mnem;
      if (dec_legal) begin
        alu_control_d = dec_ctrl;
        ctrl_valid_d  = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      offset_q      <= '0;
      presc_q       <= '0;
      mnem_q        <= pack3(G_BL, G_BL, G_BL);
      alu_control_q <= 4'b0000;
      ctrl_valid_q  <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      presc_q       <= presc_d;
      mnem_q        <= mnem_d;
      alu_control_q <= alu_control_d;
      ctrl_valid_q  <= ctrl_valid_d;
      illegal_q     <= illegal_d;
    end
  end

  logic [OW:0] idx;
  logic [6:0]  glyph;

  // Segments depend only on registered state, so there is no input-to-output path.
  always_comb begin
    seg_o = '1;
    idx   = '0;
    glyph = G_BL;
    for (int i = 0; i < DIGITS; i++) begin
      idx = {1'b0, offset_q} + (OW+1)'(i);
      if (idx >= (OW+1)'(L)) idx = idx - (OW+1)'(L);
      if (idx == (OW+1)'(0))      glyph = mnem_q[0];
      else if (idx == (OW+1)'(1)) glyph = mnem_q[1];
      else if (idx == (OW+1)'(2)) glyph = mnem_q[2];
      else                        glyph = G_BL;
      seg_o[(DIGITS-1-i)*7 +: 7] = glyph;
    end
  end

  assign alu_control_o = alu_control_q;
  assign ctrl_valid_o  = ctrl_valid_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_control_display.sv
// Bench for alu_control_display: directed scenarios plus random traffic against a cycle-counting reference model.
module tb_alu_control_display;
  localparam int DIGITS = 5;
  localparam int DIV    = 4;
  localparam int L      = DIGITS + 3;

  logic                clk = 1'b0;
  logic                rst_n, dec_valid, scroll_en;
  logic [1:0]          alu_op;
  logic [5:0]          funct;
  logic [3:0]          alu_control;
  logic                ctrl_valid, illegal;
  logic [DIGITS*7-1:0] seg;

  always #5 clk = ~clk;

  alu_control_display #(.DIGITS(DIGITS), .SCROLL_DIV(DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .dec_valid_i(dec_valid), .alu_op_i(alu_op),
    .funct_i(funct), .scroll_en_i(scroll_en), .alu_control_o(alu_control),
    .ctrl_valid_o(ctrl_valid), .illegal_o(illegal), .seg_o(seg)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: displayed text plus cycles elapsed since the marquee last restarted.
  logic [3:0] m_ctrl = 4'b0000;
  bit         m_cv = 0, m_il = 0, m_scr = 0;
  int         m_el = 0;
  string      m_mn = "   ";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph_of(input byte c);
    case (c)
      " ": return 7'h7F;  "A": return 7'h08;  "d": return 7'h21;  "S": return 7'h12;
      "u": return 7'h41;  "b": return 7'h03;  "E": return 7'h06;  "q": return 7'h18;
      "L": return 7'h47;  "t": return 7'h07;  "O": return 7'h40;  "o": return 7'h40;
      "r": return 7'h2F;  "n": return 7'h2B;
      default: return 7'h00;
    endcase
  endfunction

  task automatic decode(input logic [1:0] op, input logic [5:0] f, output bit ok,
                        output logic [3:0] c, output string s);
    ok = 1; c = 4'b0000; s = "Err";
    case (op)
      2'b00: begin c = 4'b0010; s = "LS "; end
      2'b01: begin c = 4'b0110; s = "bEq"; end
      2'b11: begin c = 4'b0000; s = "And"; end
      default:
        case (f)
          6'b100000: begin c = 4'b0010; s = "Add"; end
          6'b100010: begin c = 4'b0110; s = "Sub"; end
          6'b100100: begin c = 4'b0000; s = "And"; end
          6'b100101: begin c = 4'b0001; s = "Or "; end
          6'b101010: begin c = 4'b0111; s = "SLt"; end
`ifdef ALU_CTRL_NOR_EN
          6'b100111: begin c = 4'b1100; s = "nor"; end
`endif
          default: ok = 0;
        endcase
    endcase
  endtask

  task automatic model_edge();
    bit ok; logic [3:0] c; string s;
    if (!rst_n) begin
      m_ctrl = 4'b0000; m_cv = 0; m_il = 0; m_mn = "   "; m_scr = 0; m_el = 0;
    end else begin
      m_cv = 0; m_il = 0;
      if (dec_valid) begin
        decode(alu_op, funct, ok, c, s);
        if (ok) begin m_ctrl = c; m_cv = 1; m_mn = s; end
        else begin m_il = 1; m_mn = "Err"; end
      end
      if (!scroll_en) begin m_scr = 0; m_el = 0; end
      else if (dec_valid || !m_scr) begin m_scr = 1; m_el = 0; end
      else m_el++;
    end
  endtask

  function automatic logic [DIGITS*7-1:0] exp_seg();
    logic [DIGITS*7-1:0] e;
    int off, k;
    byte ch;
    off = m_scr ? (m_el / DIV) % L : 0;
    for (int i = 0; i < DIGITS; i++) begin
      k  = (off + i) % L;
      ch = (k < 3) ? m_mn[k] : 8'h20;
      e[(DIGITS-1-i)*7 +: 7] = glyph_of(ch);
    end
    return e;
  endfunction

  task automatic step(input bit rst, input bit dv, input logic [1:0] op,
                      input logic [5:0] f, input bit se);
    rst_n = rst; dec_valid = dv; alu_op = op; funct = f; scroll_en = se;
    @(posedge clk);
    model_edge();
    #1;
    chk("alu_control", alu_control, m_ctrl);
    chk("ctrl_valid", ctrl_valid, m_cv);
    chk("illegal", illegal, m_il);
    chk("seg", seg, exp_seg());
  endtask

  logic [5:0] legal_f [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  bit         rse;

  initial begin
    rst_n = 0; dec_valid = 0; alu_op = 2'b00; funct = 6'b0; scroll_en = 0;

    // Reset with dec_valid asserted: must be ignored.
    step(0, 1, 2'b10, 6'b100000, 0);
    step(0, 1, 2'b01, 6'b000000, 1);
    chk("reset_seg", seg, {DIGITS{7'h7F}});
    chk("reset_ctrl", alu_control, 4'b0000);

    // Static Add.
    step(1, 1, 2'b10, 6'b100000, 0);
    chk("add_seg", seg, {7'h08, 7'h21, 7'h21, 7'h7F, 7'h7F});
    chk("add_ctrl", alu_control, 4'b0010);
    step(1, 0, 2'b00, 6'b0, 0);
    chk("add_pulse_end", ctrl_valid, 1'b0);

    // Sub then illegal funct back to back.
    step(1, 1, 2'b10, 6'b100010, 0);
    step(1, 1, 2'b10, 6'b111111, 0);
    chk("err_seg", seg, {7'h06, 7'h2F, 7'h2F, 7'h7F, 7'h7F});
    chk("err_hold", alu_control, 4'b0110);
    chk("err_pulse", illegal, 1'b1);
    step(1, 0, 2'b00, 6'b0, 0);

    // Marquee of "bEq": digit 0 walks through the ring every DIV cycles.
    step(1, 1, 2'b01, 6'b0, 1);
    chk("scroll_d0_0", seg[DIGITS*7-1 -: 7], 7'h03);
    for (int i = 1; i <= 8 * DIV + 2; i++) begin
      step(1, 0, 2'b00, 6'b0, 1);
      if (i == DIV)      chk("scroll_d0_1", seg[DIGITS*7-1 -: 7], 7'h06);
      if (i == 2 * DIV)  chk("scroll_d0_2", seg[DIGITS*7-1 -: 7], 7'h18);
      if (i == 3 * DIV)  chk("scroll_d0_3", seg[DIGITS*7-1 -: 7], 7'h7F);
      if (i == 8 * DIV)  chk("scroll_wrap", seg[DIGITS*7-1 -: 7], 7'h03);
    end

    // Load landing on the prescaler terminal count.
    step(1, 1, 2'b01, 6'b0, 1);
    for (int i = 0; i < DIV - 1; i++) step(1, 0, 2'b00, 6'b0, 1);
    step(1, 1, 2'b10, 6'b100000, 1);
    chk("tc_load_seg", seg, {7'h08, 7'h21, 7'h21, 7'h7F, 7'h7F});

    // Reset mid-scroll; display stays blank until a new load.
    for (int i = 0; i < 6; i++) step(1, 0, 2'b00, 6'b0, 1);
    step(0, 0, 2'b00, 6'b0, 1);
    chk("midreset_seg", seg, {DIGITS{7'h7F}});
    chk("midreset_ctrl", alu_control, 4'b0000);
    for (int i = 0; i < 6; i++) step(1, 0, 2'b00, 6'b0, 1);
    chk("postreset_blank", seg, {DIGITS{7'h7F}});

    // NOR funct, outcome depends on build configuration.
    step(1, 1, 2'b10, 6'b100000, 0);
    step(1, 1, 2'b10, 6'b100111, 0);
`ifdef ALU_CTRL_NOR_EN
    chk("nor_ctrl", alu_control, 4'b1100);
    chk("nor_seg", seg, {7'h2B, 7'h40, 7'h2F, 7'h7F, 7'h7F});
`else
    chk("nor_ctrl_held", alu_control, 4'b0010);
    chk("nor_illegal", illegal, 1'b1);
    chk("nor_seg_err", seg, {7'h06, 7'h2F, 7'h2F, 7'h7F, 7'h7F});
`endif

    // scroll_en dropped mid-count.
    step(1, 1, 2'b00, 6'b0, 1);
    for (int i = 0; i < DIV + 2; i++) step(1, 0, 2'b00, 6'b0, 1);
    step(1, 0, 2'b00, 6'b0, 0);
    chk("drop_scroll_seg", seg, {7'h47, 7'h12, 7'h7F, 7'h7F, 7'h7F});

    // Random traffic.
    rse = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rse = ~rse;
      step($urandom_range(0, 149) != 0, $urandom_range(0, 4) == 0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom_range(0, 63)),
           rse);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
